// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo frame-buffer write path.
// Frame buffer layout: left image in columns 0..H_RES-1, right image beside it.
package stereo_pkg;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int ROW_STRIDE = 2 * H_RES;

    typedef struct packed {
        logic [7:0] value;
        logic [9:0] x;
        logic [9:0] y;
    } pixel_t;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } side_e;

    // y*ROW_STRIDE is built from shifts: 1280 = 1024 + 256.
    function automatic logic [19:0] pix_addr(input pixel_t p, input side_e side);
        logic [19:0] y_ext;
        logic [19:0] x_ext;
        y_ext = {10'd0, p.y};
        x_ext = {10'd0, p.x};
        pix_addr = (y_ext << 10) + (y_ext << 8) + x_ext
                 + ((side == SIDE_R) ? 20'(H_RES) : 20'd0);
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO of pixel records; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module pix_fifo
    import stereo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  pixel_t                   din,
    input  logic                     pop,
    output pixel_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    pixel_t        mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    // NOTE: storage has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/stereo_wr_arbiter.sv
// Merges the left and right camera streams onto the single frame-buffer write
// port: range check, per-side FIFOs, round-robin grant and a held output register.
module stereo_wr_arbiter
    import stereo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  l_value,
    input  logic [9:0]  l_x,
    input  logic [9:0]  l_y,
    input  logic        l_is_val,
    input  logic [7:0]  r_value,
    input  logic [9:0]  r_x,
    input  logic [9:0]  r_y,
    input  logic        r_is_val,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic        clr_ovf,
    output logic        l_ovf,
    output logic        r_ovf,
    output logic        l_oor,
    output logic        r_oor
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pixel_t        l_pix, r_pix, l_head, r_head, grant_pix;
    logic          l_in_range, r_in_range;
    logic          l_push, r_push, l_pop, r_pop;
    logic          l_full, r_full, l_empty, r_empty;
    logic [CW-1:0] l_count, r_count;
    logic          l_drop, r_drop, l_bad, r_bad;
    logic          can_load, grant_valid;
    side_e         grant_side, last_grant;

    assign l_pix = '{value: l_value, x: l_x, y: l_y};
    assign r_pix = '{value: r_value, x: r_x, y: r_y};

    assign l_in_range = (l_x < 10'(H_RES)) && (l_y < 10'(V_RES));
    assign r_in_range = (r_x < 10'(H_RES)) && (r_y < 10'(V_RES));

    assign l_bad  = l_is_val && !l_in_range;
    assign r_bad  = r_is_val && !r_in_range;
    assign l_push = l_is_val && l_in_range && !l_full;
    assign r_push = r_is_val && r_in_range && !r_full;
    // Occupancy at the start of the cycle decides a drop, even if a pop happens too.
    assign l_drop = l_is_val && l_in_range && (l_count == CW'(FIFO_DEPTH));
    assign r_drop = r_is_val && r_in_range && (r_count == CW'(FIFO_DEPTH));

    pix_fifo #(.DEPTH(FIFO_DEPTH)) u_l_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (l_push),
        .din     (l_pix),
        .pop     (l_pop),
        .dout    (l_head),
        .full    (l_full),
        .empty   (l_empty),
        .count   (l_count)
    );

    pix_fifo #(.DEPTH(FIFO_DEPTH)) u_r_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (r_push),
        .din     (r_pix),
        .pop     (r_pop),
        .dout    (r_head),
        .full    (r_full),
        .empty   (r_empty),
        .count   (r_count)
    );

    assign can_load = !mem_we || mem_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_side  = SIDE_L;
        if (!l_empty && !r_empty) begin
            grant_valid = 1'b1;
            grant_side  = (last_grant == SIDE_R) ? SIDE_L : SIDE_R;
        end else if (!l_empty) begin
            grant_valid = 1'b1;
            grant_side  = SIDE_L;
        end else if (!r_empty) begin
            grant_valid = 1'b1;
            grant_side  = SIDE_R;
        end
    end

    assign l_pop     = can_load && grant_valid && (grant_side == SIDE_L);
    assign r_pop     = can_load && grant_valid && (grant_side == SIDE_R);
    assign grant_pix = (grant_side == SIDE_R) ? r_head : l_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            last_grant <= SIDE_R;
        end else if (can_load) begin
            if (grant_valid) begin
                mem_we     <= 1'b1;
                mem_addr   <= pix_addr(grant_pix, grant_side);
                mem_data   <= grant_pix.value;
                last_grant <= grant_side;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    // A set event in the same cycle as clr_ovf keeps the flag high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_ovf <= 1'b0;
            r_ovf <= 1'b0;
            l_oor <= 1'b0;
            r_oor <= 1'b0;
        end else begin
            if (l_drop)       l_ovf <= 1'b1;
            else if (clr_ovf) l_ovf <= 1'b0;
            if (r_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
            if (l_bad)        l_oor <= 1'b1;
            else if (clr_ovf) l_oor <= 1'b0;
            if (r_bad)        r_oor <= 1'b1;
            else if (clr_ovf) r_oor <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stereo_wr_arbiter.sv
// Directed bench for stereo_wr_arbiter: latency, alternation, backpressure,
// range flags, corner address and asynchronous reset.
module tb_stereo_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [7:0]  l_value, r_value;
    logic [9:0]  l_x, l_y, r_x, r_y;
    logic        l_is_val, r_is_val;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        clr_ovf;
    logic        l_ovf, r_ovf, l_oor, r_oor;

    int          checks   = 0;
    int          failures = 0;
    logic [27:0] wlog [$];

    stereo_wr_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .l_value   (l_value),
        .l_x       (l_x),
        .l_y       (l_y),
        .l_is_val  (l_is_val),
        .r_value   (r_value),
        .r_x       (r_x),
        .r_y       (r_y),
        .r_is_val  (r_is_val),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .clr_ovf   (clr_ovf),
        .l_ovf     (l_ovf),
        .r_ovf     (r_ovf),
        .l_oor     (l_oor),
        .r_oor     (r_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed writes, sampled mid-cycle: {data, addr}.
    always @(negedge clk) begin
        if (mem_we && mem_ready) wlog.push_back({mem_data, mem_addr});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] data,
                               input logic [19:0] addr);
        logic [27:0] e;
        e = (idx < wlog.size()) ? wlog[idx] : 'x;
        check(tag, {4'h0, e}, {4'h0, data, addr});
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_l(input logic [7:0] v, input logic [9:0] x, input logic [9:0] y);
        l_value = v; l_x = x; l_y = y; l_is_val = 1'b1;
    endtask

    task automatic drive_r(input logic [7:0] v, input logic [9:0] x, input logic [9:0] y);
        r_value = v; r_x = x; r_y = y; r_is_val = 1'b1;
    endtask

    task automatic idle_in();
        l_is_val = 1'b0; r_is_val = 1'b0;
        l_value = '0; l_x = '0; l_y = '0;
        r_value = '0; r_x = '0; r_y = '0;
    endtask

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; clr_ovf = 1'b0;
        idle_in();
        step(3);
        check("rst_we",   mem_we,   0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_flags", {l_ovf, r_ovf, l_oor, r_oor}, 0);
        reset_n = 1'b1;
        step();

        // Single pixel: pushed at edge N, written after N+1, one cycle of mem_we.
        mem_ready = 1'b1;
        drive_l(8'hA5, 10'd5, 10'd2);
        step();
        idle_in();
        check("single_lat", mem_we, 0);
        step();
        check("single_we",   mem_we,   1);
        check("single_addr", mem_addr, 2565);
        check("single_data", mem_data, 8'hA5);
        step();
        check("single_we_drop", mem_we, 0);
        check("single_count", wlog.size(), 1);

        // Fresh reset so the first contended grant goes left.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wlog.delete();
        step();

        // Contention: both sides every other cycle.
        for (int k = 0; k < 3; k++) begin
            drive_l(8'h11, 10'd0, 10'd0);
            drive_r(8'h22, 10'd0, 10'd0);
            step();
            idle_in();
            step();
        end
        step(4);
        check("cont_count", wlog.size(), 6);
        for (int k = 0; k < 3; k++) begin
            check_write("cont_l", 2*k,   8'h11, 20'd0);
            check_write("cont_r", 2*k+1, 8'h22, 20'd640);
        end
        check("cont_ovf", {l_ovf, r_ovf}, 0);

        // Backpressure: six left pixels while the frame buffer stalls.
        wlog.delete();
        mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive_l(8'(i), 10'(i), 10'd0);
            step();
        end
        idle_in();
        check("bp_we",   mem_we,   1);
        check("bp_addr", mem_addr, 1);
        check("bp_data", mem_data, 1);
        check("bp_ovf",  l_ovf,    1);
        step(4);
        check("bp_hold_addr", mem_addr, 1);
        check("bp_hold_data", mem_data, 1);
        check("bp_hold_we",   mem_we,   1);
        check("bp_no_write",  wlog.size(), 0);
        mem_ready = 1'b1;
        step(8);
        check("bp_count", wlog.size(), 5);
        for (int i = 1; i <= 5; i++) check_write("bp_order", i-1, 8'(i), 20'(i));
        check("bp_r_ovf", r_ovf, 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("bp_clr", l_ovf, 0);

        // Range: out-of-range right pixels are discarded and flagged.
        wlog.delete();
        drive_r(8'h33, 10'd640, 10'd0);
        step();
        idle_in();
        step(3);
        check("oor_x_flag",  r_oor, 1);
        check("oor_x_l",     l_oor, 0);
        check("oor_x_nowr",  wlog.size(), 0);
        check("oor_x_we",    mem_we, 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("oor_clr", r_oor, 0);
        drive_r(8'h34, 10'd0, 10'd480);
        clr_ovf = 1'b1;
        step();
        idle_in();
        clr_ovf = 1'b0;
        check("oor_y_set_wins", r_oor, 1);
        step(3);
        check("oor_y_nowr", wlog.size(), 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("oor_y_clr", r_oor, 0);

        // Corner addresses: last pixel of each image.
        drive_r(8'h5A, 10'd639, 10'd479);
        step();
        idle_in();
        step();
        check("corner_r_addr", mem_addr, 614399);
        check("corner_r_data", mem_data, 8'h5A);
        check("corner_r_oor",  r_oor, 0);
        drive_l(8'h6B, 10'd639, 10'd479);
        step();
        idle_in();
        step();
        check("corner_l_addr", mem_addr, 613759);
        check("corner_l_oor",  l_oor, 0);
        step(2);

        // Reset mid-operation with a pending write and full-ish FIFOs.
        mem_ready = 1'b0;
        drive_l(8'h01, 10'd10, 10'd1);
        drive_r(8'h02, 10'd10, 10'd1);
        step();
        drive_l(8'h03, 10'd11, 10'd1);
        drive_r(8'h04, 10'd11, 10'd1);
        step();
        idle_in();
        drive_l(8'h05, 10'd900, 10'd0);
        step();
        idle_in();
        step();
        check("mid_pre_we",  mem_we, 1);
        check("mid_pre_oor", l_oor,  1);
        wlog.delete();
        reset_n = 1'b0;
        #1;
        check("mid_rst_we",    mem_we,   0);
        check("mid_rst_addr",  mem_addr, 0);
        check("mid_rst_flags", {l_ovf, r_ovf, l_oor, r_oor}, 0);
        step(2);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        step(5);
        check("mid_no_stale", wlog.size(), 0);
        drive_l(8'h07, 10'd3, 10'd0);
        drive_r(8'h08, 10'd3, 10'd0);
        step();
        idle_in();
        step(4);
        check("mid_count", wlog.size(), 2);
        check_write("mid_first_l",  0, 8'h07, 20'd3);
        check_write("mid_second_r", 1, 8'h08, 20'd643);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
